// File: rtl/vrf_pkg.sv
// Shared types for the VRF read-request channel and its bank-side responder.
package vrf_pkg;

   localparam int VRF_ADDR_WIDTH = 9;

   // One read request as presented by the per-bank arbiter.
   typedef struct packed {
      logic [4:0] vs;
      logic [1:0] readSource;
      logic [3:0] offset;
      logic [2:0] instructionIndex;
   } vrf_read_req_t;

   // The part of a request that travels alongside the SRAM access and is echoed back.
   typedef struct packed {
      logic [1:0] readSource;
      logic [2:0] instructionIndex;
   } vrf_read_resp_tag_t;

   localparam int VRF_TAG_WIDTH = $bits(vrf_read_resp_tag_t);

   // Bank SRAM word address: register index in the high bits, word offset in the low bits.
   function automatic logic [VRF_ADDR_WIDTH-1:0] vrf_addr(input vrf_read_req_t req);
      return {req.vs, req.offset};
   endfunction

   // Strip a request down to the tag that rides the read pipeline.
   function automatic vrf_read_resp_tag_t vrf_tag(input vrf_read_req_t req);
      vrf_read_resp_tag_t tag;
      tag.readSource       = req.readSource;
      tag.instructionIndex = req.instructionIndex;
      return tag;
   endfunction

endpackage

// File: rtl/vrf_resp_fifo.sv
// Small synchronous FIFO holding completed read responses until the consumer takes them.
// DEPTH must be a power of two so the pointers wrap naturally.
module vrf_resp_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enq,
   input  logic [WIDTH-1:0] enq_data,
   input  logic             deq,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("vrf_resp_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_enq;
   logic             do_deq;

   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign do_enq    = enq & ~full;
   assign do_deq    = deq & ~empty;
   assign head_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_deq) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_enq && !do_deq) begin
            count <= count + CNT_W'(1);
         end else if (!do_enq && do_deq) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: nothing is visible until the count says an entry is valid.
   always_ff @(posedge clock) begin
      if (do_enq) begin
         mem[wr_ptr] <= enq_data;
      end
   end

endmodule

// File: rtl/vrf_read_responder.sv
// Bank-side responder: turns accepted read requests into SRAM reads, carries each
// request's tag through a fixed-latency pipeline and queues data+tag for the consumer.
// Credits are reserved at request time, so returning SRAM data always has a slot.
module vrf_read_responder
   import vrf_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 2,
   parameter int RESP_DEPTH   = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      io_in_ready,
   input  logic                      io_in_valid,
   input  logic [4:0]                io_in_bits_vs,
   input  logic [1:0]                io_in_bits_readSource,
   input  logic [3:0]                io_in_bits_offset,
   input  logic [2:0]                io_in_bits_instructionIndex,
   input  logic                      io_out_ready,
   output logic                      io_out_valid,
   output logic [DATA_WIDTH-1:0]     io_out_bits_data,
   output logic [1:0]                io_out_bits_readSource,
   output logic [2:0]                io_out_bits_instructionIndex,
   output logic                      sram_ren,
   output logic [VRF_ADDR_WIDTH-1:0] sram_addr,
   input  logic [DATA_WIDTH-1:0]     sram_rdata
);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("vrf_read_responder: READ_LATENCY must be within 1..4");
   end
   if (RESP_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
      $error("vrf_read_responder: RESP_DEPTH must be at least READ_LATENCY+1");
   end

   localparam int OCC_W   = $clog2(RESP_DEPTH + 1);
   localparam int ENTRY_W = DATA_WIDTH + VRF_TAG_WIDTH;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RESP_DEPTH);

   vrf_read_req_t      req;
   vrf_read_resp_tag_t req_tag;
   vrf_read_resp_tag_t head_tag;
   logic [OCC_W-1:0]   occ;
   logic               in_ready;
   logic               fire;
   logic               out_valid;
   logic               deq;
   logic               enq_valid;
   logic [ENTRY_W-1:0] enq_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic               fifo_full;
   logic               fifo_empty;

   logic               pipe_valid [READ_LATENCY];
   vrf_read_resp_tag_t pipe_tag   [READ_LATENCY];

   assign req.vs               = io_in_bits_vs;
   assign req.readSource       = io_in_bits_readSource;
   assign req.offset           = io_in_bits_offset;
   assign req.instructionIndex = io_in_bits_instructionIndex;
   assign req_tag              = vrf_tag(req);

   // Acceptance depends only on the registered occupancy, never on io_out_ready.
   assign in_ready    = (occ < OCC_FULL) & ~reset;
   assign fire        = io_in_valid & in_ready;
   assign io_in_ready = in_ready;

   // The SRAM read is issued in the same cycle the request is accepted.
   assign sram_ren  = fire;
   assign sram_addr = vrf_addr(req);

   // Valid bits of the tag pipeline; cleared on reset so late data from
   // discarded requests never reaches the response FIFO.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= 1'b0;
         end
      end else begin
         pipe_valid[0] <= fire;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
         end
      end
   end

   // Tag payload shifts every cycle in step with the valid bits; it is only
   // consumed where the matching valid is set, so it needs no reset.
   always_ff @(posedge clock) begin
      pipe_tag[0] <= req_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_tag[i] <= pipe_tag[i-1];
      end
   end

   // The last pipeline stage lines up with the cycle sram_rdata belongs to its request.
   assign enq_valid = pipe_valid[READ_LATENCY-1];
   assign enq_entry = {sram_rdata, pipe_tag[READ_LATENCY-1]};

   vrf_resp_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clock     (clock),
      .reset     (reset),
      .enq       (enq_valid),
      .enq_data  (enq_entry),
      .deq       (deq),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid    = ~fifo_empty & ~reset;
   assign deq          = out_valid & io_out_ready;
   assign io_out_valid = out_valid;

   assign io_out_bits_data             = head_entry[ENTRY_W-1 -: DATA_WIDTH];
   assign head_tag                     = vrf_read_resp_tag_t'(head_entry[VRF_TAG_WIDTH-1:0]);
   assign io_out_bits_readSource       = head_tag.readSource;
   assign io_out_bits_instructionIndex = head_tag.instructionIndex;

   // Credit counter: in-flight reads plus queued responses, bumped by each accept
   // and dropped by each dequeue.
   always_ff @(posedge clock) begin
      if (reset) begin
         occ <= '0;
      end else begin
         case ({fire, deq})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Credits reserved at accept time mean returning data always finds a free slot.
   no_overrun: assert property (@(posedge clock) disable iff (reset) enq_valid |-> !fifo_full);

endmodule

// File: tb/tb_vrf_read_responder.sv
// Self-checking bench for vrf_read_responder: a default build (latency 2, depth 4)
// and a small build (latency 1, depth 2) checked every cycle against a queue model.
module tb_vrf_read_responder;

   localparam int NU = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_sig    [NU];
   logic        in_valid     [NU];
   logic [4:0]  in_vs        [NU];
   logic [1:0]  in_rs        [NU];
   logic [3:0]  in_off       [NU];
   logic [2:0]  in_ii        [NU];
   logic        out_ready    [NU];
   logic        in_ready     [NU];
   logic        out_valid    [NU];
   logic [31:0] out_data     [NU];
   logic [1:0]  out_rs       [NU];
   logic [2:0]  out_ii       [NU];
   logic        sram_ren     [NU];
   logic [8:0]  sram_addr    [NU];
   logic [31:0] sram_rdata   [NU];

   int n_checks = 0;
   int n_fail   = 0;
   int fires_seen [NU];
   int resps_seen [NU];

   vrf_read_responder #(.DATA_WIDTH(32), .READ_LATENCY(2), .RESP_DEPTH(4)) dut_a (
      .clock (clock), .reset (reset_sig[0]),
      .io_in_ready (in_ready[0]), .io_in_valid (in_valid[0]),
      .io_in_bits_vs (in_vs[0]), .io_in_bits_readSource (in_rs[0]),
      .io_in_bits_offset (in_off[0]), .io_in_bits_instructionIndex (in_ii[0]),
      .io_out_ready (out_ready[0]), .io_out_valid (out_valid[0]),
      .io_out_bits_data (out_data[0]), .io_out_bits_readSource (out_rs[0]),
      .io_out_bits_instructionIndex (out_ii[0]),
      .sram_ren (sram_ren[0]), .sram_addr (sram_addr[0]), .sram_rdata (sram_rdata[0])
   );

   vrf_read_responder #(.DATA_WIDTH(32), .READ_LATENCY(1), .RESP_DEPTH(2)) dut_b (
      .clock (clock), .reset (reset_sig[1]),
      .io_in_ready (in_ready[1]), .io_in_valid (in_valid[1]),
      .io_in_bits_vs (in_vs[1]), .io_in_bits_readSource (in_rs[1]),
      .io_in_bits_offset (in_off[1]), .io_in_bits_instructionIndex (in_ii[1]),
      .io_out_ready (out_ready[1]), .io_out_valid (out_valid[1]),
      .io_out_bits_data (out_data[1]), .io_out_bits_readSource (out_rs[1]),
      .io_out_bits_instructionIndex (out_ii[1]),
      .sram_ren (sram_ren[1]), .sram_addr (sram_addr[1]), .sram_rdata (sram_rdata[1])
   );

   function automatic int lat_of(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   function automatic int depth_of(input int u);
      return (u == 0) ? 4 : 2;
   endfunction

   // Bank contents: every address holds a distinct, easily recognised word.
   function automatic logic [31:0] mem_word(input logic [8:0] a);
      return {16'hC0DE, 7'd0, a};
   endfunction

   // SRAM models: data appears READ_LATENCY cycles after the read, junk otherwise.
   logic [31:0] rd_a1 = '0;
   logic [31:0] rd_a2 = '0;
   logic [31:0] rd_b1 = '0;
   always @(posedge clock) begin
      rd_a1 <= sram_ren[0] ? mem_word(sram_addr[0]) : 32'hBAD0_0000;
      rd_a2 <= rd_a1;
      rd_b1 <= sram_ren[1] ? mem_word(sram_addr[1]) : 32'hBAD1_0000;
   end
   assign sram_rdata[0] = rd_a2;
   assign sram_rdata[1] = rd_b1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: requests accepted while fewer than DEPTH are outstanding,
   // each becomes a queued response LATENCY+1 cycles later, served strictly in order.
   typedef struct {
      int          unit;
      int          due;
      logic [31:0] data;
      logic [1:0]  rs;
      logic [2:0]  ii;
   } item_t;

   item_t pend_q [$];
   item_t resp_q [$];
   int    m_occ [NU];
   int    cyc = 0;

   function automatic int head_index(input int u);
      for (int i = 0; i < resp_q.size(); i++) begin
         if (resp_q[i].unit == u) return i;
      end
      return -1;
   endfunction

   task automatic modelStep(input int u);
      bit    exp_ready;
      bit    exp_fire;
      bit    exp_valid;
      bit    do_deq;
      int    h;
      int    i;
      item_t it;
      exp_ready = !reset_sig[u] && (m_occ[u] < depth_of(u));
      exp_fire  = in_valid[u] && exp_ready;
      h         = head_index(u);
      exp_valid = !reset_sig[u] && (h >= 0);
      checkOutput($sformatf("u%0d io_in_ready", u), 64'(in_ready[u]), 64'(exp_ready));
      checkOutput($sformatf("u%0d sram_ren", u), 64'(sram_ren[u]), 64'(exp_fire));
      if (exp_fire) begin
         checkOutput($sformatf("u%0d sram_addr", u), 64'(sram_addr[u]), 64'({in_vs[u], in_off[u]}));
      end
      checkOutput($sformatf("u%0d io_out_valid", u), 64'(out_valid[u]), 64'(exp_valid));
      if (exp_valid) begin
         checkOutput($sformatf("u%0d out data", u), 64'(out_data[u]), 64'(resp_q[h].data));
         checkOutput($sformatf("u%0d out readSource", u), 64'(out_rs[u]), 64'(resp_q[h].rs));
         checkOutput($sformatf("u%0d out instrIdx", u), 64'(out_ii[u]), 64'(resp_q[h].ii));
      end
      if (reset_sig[u]) begin
         i = 0;
         while (i < pend_q.size()) begin
            if (pend_q[i].unit == u) pend_q.delete(i); else i++;
         end
         i = 0;
         while (i < resp_q.size()) begin
            if (resp_q[i].unit == u) resp_q.delete(i); else i++;
         end
         m_occ[u] = 0;
      end else begin
         do_deq = exp_valid && out_ready[u];
         if (do_deq) resp_q.delete(h);
         i = 0;
         while (i < pend_q.size()) begin
            if (pend_q[i].unit == u && pend_q[i].due == cyc) begin
               resp_q.push_back(pend_q[i]);
               pend_q.delete(i);
            end else begin
               i++;
            end
         end
         if (exp_fire) begin
            it.unit = u;
            it.due  = cyc + lat_of(u);
            it.data = mem_word({in_vs[u], in_off[u]});
            it.rs   = in_rs[u];
            it.ii   = in_ii[u];
            pend_q.push_back(it);
         end
         m_occ[u] = m_occ[u] + int'(exp_fire) - int'(do_deq);
      end
   endtask

   // Compare process: mid-cycle, inputs are stable and outputs settled.
   always @(negedge clock) begin
      for (int u = 0; u < NU; u++) modelStep(u);
      cyc++;
   end

   // Drive one cycle for unit u, then return once that cycle's outputs are stable.
   task automatic applyStimulus(input int u, input logic rst, input logic valid,
                                input logic [4:0] vs, input logic [1:0] rs,
                                input logic [3:0] off, input logic [2:0] ii, input logic ordy);
      @(posedge clock);
      #1;
      reset_sig[u] = rst;
      in_valid[u]  = valid;
      in_vs[u]     = vs;
      in_rs[u]     = rs;
      in_off[u]    = off;
      in_ii[u]     = ii;
      out_ready[u] = ordy;
      @(negedge clock);
      #1;
      if (in_valid[u] && in_ready[u]) fires_seen[u]++;
      if (out_valid[u] && out_ready[u]) resps_seen[u]++;
   endtask

   task automatic idle(input int u, input logic ordy);
      applyStimulus(u, 1'b0, 1'b0, 5'd0, 2'd0, 4'd0, 3'd0, ordy);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      int f0;
      int r0;
      int first_resp;
      int last_resp;
      int idx;
      for (int u = 0; u < NU; u++) begin
         reset_sig[u] = 1'b1; in_valid[u] = 1'b0; in_vs[u] = '0; in_rs[u] = '0;
         in_off[u] = '0; in_ii[u] = '0; out_ready[u] = 1'b0;
         fires_seen[u] = 0; resps_seen[u] = 0; m_occ[u] = 0;
      end

      // Reset state
      repeat (3) applyStimulus(0, 1'b1, 1'b1, 5'd1, 2'd1, 4'd1, 3'd1, 1'b1);
      checkOutput("reset in_ready", 64'(in_ready[0]), 64'd0);
      checkOutput("reset sram_ren", 64'(sram_ren[0]), 64'd0);
      checkOutput("reset out_valid", 64'(out_valid[0]), 64'd0);

      // Single request: address and three-cycle return latency pinned by hand
      $display("[TB] single request");
      applyStimulus(0, 1'b0, 1'b1, 5'd3, 2'd2, 4'd5, 3'd6, 1'b1);
      checkOutput("t1 sram_ren", 64'(sram_ren[0]), 64'd1);
      checkOutput("t1 sram_addr", 64'(sram_addr[0]), 64'h035);
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
         idle(0, 1'b1);
         if (out_valid[0]) begin
            lat = k;
            break;
         end
      end
      checkOutput("t1 latency", 64'(lat), 64'd3);
      checkOutput("t1 data", 64'(out_data[0]), 64'hC0DE0035);
      checkOutput("t1 readSource", 64'(out_rs[0]), 64'd2);
      checkOutput("t1 instrIdx", 64'(out_ii[0]), 64'd6);
      repeat (3) idle(0, 1'b1);

      // 16 back-to-back requests with the consumer always ready
      $display("[TB] back-to-back");
      f0 = fires_seen[0]; r0 = resps_seen[0]; first_resp = -1; last_resp = -1;
      for (int n = 0; n < 26; n++) begin
         if (n < 16) begin
            applyStimulus(0, 1'b0, 1'b1, 5'(n), 2'(n % 4), 4'(15 - n), 3'(n % 8), 1'b1);
         end else begin
            idle(0, 1'b1);
         end
         if (out_valid[0]) begin
            if (first_resp < 0) first_resp = n;
            last_resp = n;
         end
      end
      checkOutput("t2 accepted", 64'(fires_seen[0] - f0), 64'd16);
      checkOutput("t2 responses", 64'(resps_seen[0] - r0), 64'd16);
      checkOutput("t2 first response", 64'(first_resp), 64'd3);
      checkOutput("t2 response span", 64'(last_resp - first_resp), 64'd15);

      // Backpressure: 10 requests offered, only 4 fit while the consumer stalls
      $display("[TB] backpressure");
      f0 = fires_seen[0]; r0 = resps_seen[0]; idx = 0;
      for (int n = 0; n < 8; n++) begin
         applyStimulus(0, 1'b0, 1'b1, 5'(16 + idx), 2'(idx % 4), 4'(idx), 3'((idx + 1) % 8), 1'b0);
         if (in_ready[0]) idx++;
      end
      checkOutput("t3 accepted while stalled", 64'(idx), 64'd4);
      checkOutput("t3 in_ready when full", 64'(in_ready[0]), 64'd0);

      // One-cycle ready pulse at full occupancy lets exactly one more request in next cycle
      applyStimulus(0, 1'b0, 1'b1, 5'(16 + idx), 2'(idx % 4), 4'(idx), 3'((idx + 1) % 8), 1'b1);
      checkOutput("t4 no fire in pulse cycle", 64'(in_ready[0]), 64'd0);
      checkOutput("t4 valid in pulse cycle", 64'(out_valid[0]), 64'd1);
      applyStimulus(0, 1'b0, 1'b1, 5'(16 + idx), 2'(idx % 4), 4'(idx), 3'((idx + 1) % 8), 1'b0);
      checkOutput("t4 fire after pulse", 64'(in_ready[0]), 64'd1);
      if (in_ready[0]) idx++;
      applyStimulus(0, 1'b0, 1'b1, 5'(16 + idx), 2'(idx % 4), 4'(idx), 3'((idx + 1) % 8), 1'b0);
      checkOutput("t4 full again", 64'(in_ready[0]), 64'd0);
      checkOutput("t4 accepted total", 64'(idx), 64'd5);
      for (int n = 0; n < 40 && idx < 10; n++) begin
         applyStimulus(0, 1'b0, 1'b1, 5'(16 + idx), 2'(idx % 4), 4'(idx), 3'((idx + 1) % 8), 1'b1);
         if (in_ready[0]) idx++;
      end
      repeat (8) idle(0, 1'b1);
      checkOutput("t3 accepted total", 64'(fires_seen[0] - f0), 64'd10);
      checkOutput("t3 responses total", 64'(resps_seen[0] - r0), 64'd10);

      // Reset one cycle after two fires: nothing in flight may survive
      $display("[TB] reset with reads in flight");
      applyStimulus(0, 1'b0, 1'b1, 5'd7, 2'd1, 4'd1, 3'd1, 1'b1);
      applyStimulus(0, 1'b0, 1'b1, 5'd7, 2'd2, 4'd2, 3'd2, 1'b1);
      applyStimulus(0, 1'b1, 1'b1, 5'd7, 2'd3, 4'd3, 3'd3, 1'b1);
      checkOutput("t5 in_ready during reset", 64'(in_ready[0]), 64'd0);
      checkOutput("t5 sram_ren during reset", 64'(sram_ren[0]), 64'd0);
      r0 = resps_seen[0];
      repeat (6) idle(0, 1'b1);
      checkOutput("t5 no stale responses", 64'(resps_seen[0] - r0), 64'd0);
      applyStimulus(0, 1'b0, 1'b1, 5'd9, 2'd1, 4'd10, 3'd5, 1'b1);
      checkOutput("t5 sram_addr", 64'(sram_addr[0]), 64'h09A);
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
         idle(0, 1'b1);
         if (out_valid[0]) begin
            lat = k;
            break;
         end
      end
      checkOutput("t5 latency", 64'(lat), 64'd3);
      checkOutput("t5 data", 64'(out_data[0]), 64'hC0DE009A);
      checkOutput("t5 readSource", 64'(out_rs[0]), 64'd1);
      checkOutput("t5 instrIdx", 64'(out_ii[0]), 64'd5);
      repeat (3) idle(0, 1'b1);

      // Small build: random valid/ready stress of 1000 requests
      $display("[TB] latency-1 depth-2 stress");
      repeat (2) applyStimulus(1, 1'b1, 1'b0, 5'd0, 2'd0, 4'd0, 3'd0, 1'b0);
      f0 = fires_seen[1]; r0 = resps_seen[1];
      for (int c = 0; c < 20000 && (fires_seen[1] - f0) < 1000; c++) begin
         applyStimulus(1, 1'b0, ($urandom_range(0, 3) != 0), 5'($urandom), 2'($urandom),
                       4'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0));
      end
      repeat (8) idle(1, 1'b1);
      checkOutput("t6 accepted", 64'(fires_seen[1] - f0), 64'd1000);
      checkOutput("t6 responses", 64'(resps_seen[1] - r0), 64'd1000);
      checkOutput("t6 drained", 64'(out_valid[1]), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
